// File: rtl/relobi_fault_monitor.sv
// relobi_fault_monitor: aggregates {uncorrectable, corrected} fault flags from
// reliable-OBI components into saturating counters, a sticky health state,
// a first-uncorrectable capture and a threshold/failure interrupt.
module relobi_fault_monitor #(
    parameter int unsigned NumSources = 16,
    parameter int unsigned CntWidth   = 16,
    parameter bit          RegInputs  = 1'b1,
    parameter int unsigned IdxWidth   = (NumSources > 1) ? $clog2(NumSources) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumSources-1:0][1:0] fault_i,
    input  logic [NumSources-1:0]      mask_i,
    input  logic                       clear_i,
    input  logic [CntWidth-1:0]        threshold_i,
    output logic [CntWidth-1:0]        corr_cnt_o,
    output logic [CntWidth-1:0]        uncorr_cnt_o,
    output logic [1:0]                 state_o,
    output logic                       first_valid_o,
    output logic [IdxWidth-1:0]        first_idx_o,
    output logic                       irq_o
);

    localparam int unsigned PopWidth = $clog2(NumSources + 1);
    localparam int unsigned SumWidth = CntWidth + PopWidth;
    localparam logic [CntWidth-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        StOk   = 2'd0,
        StCorr = 2'd1,
        StFail = 2'd2
    } state_e;

    logic [NumSources-1:0][1:0] src_w;
    logic [NumSources-1:0][1:0] f_w;
    logic [PopWidth-1:0]        nc_w;
    logic [PopWidth-1:0]        nu_w;
    logic [IdxWidth-1:0]        low_idx_w;

    logic [CntWidth-1:0] corr_q, corr_d;
    logic [CntWidth-1:0] uncorr_q, uncorr_d;
    state_e              state_q, state_d;
    logic                first_valid_q, first_valid_d;
    logic [IdxWidth-1:0] first_idx_q, first_idx_d;
    logic                irq_q, irq_d;

    // Optional input stage; intentionally not affected by clear so in-flight faults survive it.
    generate
        if (RegInputs) begin : g_reg_in
            logic [NumSources-1:0][1:0] fault_q;

            // Capture raw fault flags one cycle before evaluation.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    fault_q <= '0;
                end else begin
                    fault_q <= fault_i;
                end
            end

            assign src_w = fault_q;
        end else begin : g_direct_in
            assign src_w = fault_i;
        end
    endgenerate

    // Masking happens at evaluation time so a late mask still hides a registered fault.
    always_comb begin
        f_w = '0;
        for (int unsigned i = 0; i < NumSources; i++) begin
            f_w[i] = mask_i[i] ? 2'b00 : src_w[i];
        end
    end

    // Per-cycle event counts; a source with both bits set counts in both.
    always_comb begin
        nc_w = '0;
        nu_w = '0;
        for (int unsigned i = 0; i < NumSources; i++) begin
            nc_w = nc_w + PopWidth'(f_w[i][0]);
            nu_w = nu_w + PopWidth'(f_w[i][1]);
        end
    end

    // Lowest-index source currently flagging an uncorrectable fault.
    always_comb begin
        low_idx_w = '0;
        for (int i = int'(NumSources) - 1; i >= 0; i--) begin
            if (f_w[i][1]) begin
                low_idx_w = IdxWidth'(i);
            end
        end
    end

    // Widen before adding so the sum cannot wrap, then clamp at all-ones.
    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                    input logic [PopWidth-1:0] n);
        logic [SumWidth-1:0] s;
        s = SumWidth'(a) + SumWidth'(n);
        return (s > SumWidth'(CntMax)) ? CntMax : s[CntWidth-1:0];
    endfunction

    // Next-state: clear restarts from the reset values, then the same-cycle faults are applied.
    always_comb begin
        logic [CntWidth-1:0] corr_base;
        logic [CntWidth-1:0] uncorr_base;
        state_e              state_base;
        logic                valid_base;

        corr_base     = clear_i ? {CntWidth{1'b0}} : corr_q;
        uncorr_base   = clear_i ? {CntWidth{1'b0}} : uncorr_q;
        state_base    = clear_i ? StOk : state_q;
        valid_base    = clear_i ? 1'b0 : first_valid_q;

        corr_d        = sat_add(corr_base, nc_w);
        uncorr_d      = sat_add(uncorr_base, nu_w);

        state_d       = state_base;
        if (nu_w != '0) begin
            state_d = StFail;
        end else if ((state_base == StOk) && (nc_w != '0)) begin
            state_d = StCorr;
        end

        first_valid_d = valid_base;
        first_idx_d   = clear_i ? {IdxWidth{1'b0}} : first_idx_q;
        if (!valid_base && (nu_w != '0)) begin
            first_valid_d = 1'b1;
            first_idx_d   = low_idx_w;
        end

        irq_d = (state_d == StFail) ||
                ((threshold_i != '0) && (corr_d >= threshold_i));
    end

    // Monitor state registers; every output comes straight from one of these.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_q        <= '0;
            uncorr_q      <= '0;
            state_q       <= StOk;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            irq_q         <= 1'b0;
        end else begin
            corr_q        <= corr_d;
            uncorr_q      <= uncorr_d;
            state_q       <= state_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            irq_q         <= irq_d;
        end
    end

    assign corr_cnt_o    = corr_q;
    assign uncorr_cnt_o  = uncorr_q;
    assign state_o       = state_q;
    assign first_valid_o = first_valid_q;
    assign first_idx_o   = first_idx_q;
    assign irq_o         = irq_q;

`ifndef SYNTHESIS
    // Control inputs must be driven once out of reset.
    a_clear_known : assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(clear_i));
    a_thresh_known : assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(threshold_i));
`endif

endmodule

// File: tb/tb_relobi_fault_monitor.sv
// Directed bench for relobi_fault_monitor: a default instance (registered inputs),
// a 4-bit-counter direct-input instance and a single-source instance.
module tb_relobi_fault_monitor;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0][1:0]  fault;
    logic [15:0]       mask;
    logic              clear;
    logic [15:0]       thr_a;
    logic [3:0]        thr_b;
    logic [3:0]        thr_c;
    logic [0:0][1:0]   fault_c;
    logic [0:0]        mask_c;

    logic [15:0] corr_a, uncorr_a;
    logic [1:0]  state_a;
    logic        fv_a, irq_a;
    logic [3:0]  fi_a;
    logic [3:0]  corr_b, uncorr_b;
    logic [1:0]  state_b;
    logic        fv_b, irq_b;
    logic [3:0]  fi_b;
    logic [3:0]  corr_c, uncorr_c;
    logic [1:0]  state_c;
    logic        fv_c, irq_c;
    logic [0:0]  fi_c;

    int n_cmp = 0;
    int n_err = 0;

    wire [39:0] obs_a = {corr_a, uncorr_a, state_a, fv_a, fi_a, irq_a};
    wire [15:0] obs_b = {corr_b, uncorr_b, state_b, fv_b, fi_b, irq_b};
    wire [12:0] obs_c = {corr_c, uncorr_c, state_c, fv_c, fi_c, irq_c};

    assign fault_c[0] = fault[1];
    assign mask_c[0]  = mask[1];

    always #5 clk = ~clk;

    relobi_fault_monitor #(.NumSources(16), .CntWidth(16), .RegInputs(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault), .mask_i(mask), .clear_i(clear),
        .threshold_i(thr_a), .corr_cnt_o(corr_a), .uncorr_cnt_o(uncorr_a), .state_o(state_a),
        .first_valid_o(fv_a), .first_idx_o(fi_a), .irq_o(irq_a));

    relobi_fault_monitor #(.NumSources(16), .CntWidth(4), .RegInputs(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault), .mask_i(mask), .clear_i(clear),
        .threshold_i(thr_b), .corr_cnt_o(corr_b), .uncorr_cnt_o(uncorr_b), .state_o(state_b),
        .first_valid_o(fv_b), .first_idx_o(fi_b), .irq_o(irq_b));

    relobi_fault_monitor #(.NumSources(1), .CntWidth(4), .RegInputs(1'b0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault_c), .mask_i(mask_c), .clear_i(clear),
        .threshold_i(thr_c), .corr_cnt_o(corr_c), .uncorr_cnt_o(uncorr_c), .state_o(state_c),
        .first_valid_o(fv_c), .first_idx_o(fi_c), .irq_o(irq_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flush the input register with zeros, then pulse clear.
    task automatic do_clear();
        fault = '0;
        mask  = '0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fault = '0;
        mask  = '0;
        clear = 1'b0;
        thr_a = '0;
        thr_b = '0;
        thr_c = '0;
        repeat (3) step();
        n_cmp++;
        if ({obs_a, obs_b, obs_c} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_hold: got a=%h b=%h c=%h want all 0", obs_a, obs_b, obs_c);
        end
        #2 rst_n = 1'b1;
        repeat (10) step();
        n_cmp++;
        if ({obs_a, obs_b, obs_c} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_idle: got a=%h b=%h c=%h want all 0", obs_a, obs_b, obs_c);
        end
    endtask

    task automatic test_corrected_burst();
        logic [39:0] ea [5];
        ea[0] = 40'd0;
        ea[1] = {16'd2, 16'd0, 2'd1, 1'b0, 4'd0, 1'b0};
        ea[2] = {16'd4, 16'd0, 2'd1, 1'b0, 4'd0, 1'b0};
        ea[3] = {16'd6, 16'd0, 2'd1, 1'b0, 4'd0, 1'b1};
        ea[4] = {16'd6, 16'd0, 2'd1, 1'b0, 4'd0, 1'b1};
        do_clear();
        thr_a    = 16'd6;
        fault[2] = 2'b01;
        fault[5] = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 2) fault = '0;
            n_cmp++;
            if (obs_a !== ea[i]) begin
                n_err++;
                $display("FAIL corr_burst[%0d]: got %h want %h", i, obs_a, ea[i]);
            end
        end
        thr_a = 16'd0;
        step();
        n_cmp++;
        if (obs_a !== {16'd6, 16'd0, 2'd1, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL thr_disable: got %h want irq low, cnt 6", obs_a);
        end
    endtask

    task automatic test_uncorrectable();
        do_clear();
        fault[9] = 2'b10;
        fault[3] = 2'b10;
        step();
        fault = '0;
        n_cmp++;
        if (obs_a !== 40'd0) begin
            n_err++;
            $display("FAIL uncorr_latency: got %h want 0", obs_a);
        end
        step();
        n_cmp++;
        if (obs_a !== {16'd0, 16'd2, 2'd2, 1'b1, 4'd3, 1'b1}) begin
            n_err++;
            $display("FAIL uncorr_first: got %h want cnt 2 idx 3 failed irq", obs_a);
        end
        fault[1] = 2'b10;
        step();
        fault = '0;
        n_cmp++;
        if (obs_c !== {4'd0, 4'd1, 2'd2, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL single_src: got %h want cnt 1 idx 0 failed irq", obs_c);
        end
        step();
        n_cmp++;
        if (obs_a !== {16'd0, 16'd3, 2'd2, 1'b1, 4'd3, 1'b1}) begin
            n_err++;
            $display("FAIL uncorr_keep: got %h want cnt 3 idx 3", obs_a);
        end
    endtask

    task automatic test_both_bits();
        do_clear();
        fault[4] = 2'b11;
        step();
        fault = '0;
        n_cmp++;
        if (obs_b !== {4'd1, 4'd1, 2'd2, 1'b1, 4'd4, 1'b1}) begin
            n_err++;
            $display("FAIL both_bits: got %h want corr 1 uncorr 1 idx 4", obs_b);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        thr_b = 4'd15;
        for (int i = 0; i < 16; i++) fault[i] = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) fault = '0;
            n_cmp++;
            if (obs_b !== {4'd15, 4'd0, 2'd1, 1'b0, 4'd0, 1'b1}) begin
                n_err++;
                $display("FAIL saturate[%0d]: got %h want corr 15 irq", i, obs_b);
            end
        end
        thr_b = 4'd0;
        do_clear();
        n_cmp++;
        if (obs_b !== 16'd0) begin
            n_err++;
            $display("FAIL sat_clear: got %h want 0", obs_b);
        end
    endtask

    task automatic test_clear_same_cycle();
        do_clear();
        fault[5] = 2'b10;
        step();
        n_cmp++;
        if (obs_b !== {4'd0, 4'd1, 2'd2, 1'b1, 4'd5, 1'b1}) begin
            n_err++;
            $display("FAIL pre_clear: got %h want uncorr 1 idx 5", obs_b);
        end
        fault    = '0;
        fault[0] = 2'b10;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        fault = '0;
        n_cmp++;
        if (obs_b !== {4'd0, 4'd1, 2'd2, 1'b1, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL clear_recapture: got %h want uncorr 1 idx 0", obs_b);
        end
        step();
        n_cmp++;
        if (obs_b !== {4'd0, 4'd1, 2'd2, 1'b1, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL clear_hold: got %h want uncorr 1 idx 0", obs_b);
        end
        fault[0] = 2'b10;
        mask[0]  = 1'b1;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        fault = '0;
        mask  = '0;
        n_cmp++;
        if (obs_b !== 16'd0) begin
            n_err++;
            $display("FAIL clear_masked: got %h want 0", obs_b);
        end
    endtask

    task automatic test_inflight_and_mask();
        do_clear();
        fault[7] = 2'b10;
        step();
        fault = '0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++;
        if (obs_a !== {16'd0, 16'd1, 2'd2, 1'b1, 4'd7, 1'b1}) begin
            n_err++;
            $display("FAIL inflight_clear: got %h want uncorr 1 idx 7", obs_a);
        end
        do_clear();
        fault[6] = 2'b10;
        step();
        fault   = '0;
        mask[6] = 1'b1;
        step();
        mask = '0;
        n_cmp++;
        if (obs_a !== 40'd0) begin
            n_err++;
            $display("FAIL late_mask: got %h want 0", obs_a);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        fault[2] = 2'b01;
        step();
        step();
        n_cmp++;
        if (obs_b !== {4'd2, 4'd0, 2'd1, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL pre_reset: got %h want corr 2", obs_b);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs_a, obs_b, obs_c} !== 69'd0) begin
            n_err++;
            $display("FAIL async_reset: got a=%h b=%h c=%h want all 0", obs_a, obs_b, obs_c);
        end
        #10;
        n_cmp++;
        if ({obs_a, obs_b, obs_c} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_held: got a=%h b=%h c=%h want all 0", obs_a, obs_b, obs_c);
        end
        #2 rst_n = 1'b1;
        step();
        n_cmp++;
        if ({obs_a, obs_b} !== {40'd0, 4'd1, 4'd0, 2'd1, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset_1: got a=%h b=%h want a 0, b corr 1", obs_a, obs_b);
        end
        step();
        fault = '0;
        n_cmp++;
        if ({obs_a, obs_b} !== {16'd1, 16'd0, 2'd1, 1'b0, 4'd0, 1'b0,
                                4'd2, 4'd0, 2'd1, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset_2: got a=%h b=%h want a corr 1, b corr 2", obs_a, obs_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_corrected_burst();
        test_uncorrectable();
        test_both_bits();
        test_saturation();
        test_clear_same_cycle();
        test_inflight_and_mask();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/relobi_fault_monitor.md
Name: relobi_fault_monitor

Overview:
Sequential fault aggregator for reliable-OBI subsystems: collects the 2-bit {uncorrectable, corrected} fault flags from NumSources relobi components (encoders, decoders, xbars), keeps saturating event counters, a sticky health state, and first-failure capture, and raises an interrupt on a programmable threshold. Sits beside a relobi interconnect; its outputs feed a status register file or a safety controller.

Parameters:
NumSources, 16, number of fault sources (≥1)
CntWidth, 16, width of each event counter
RegInputs, 1'b1, 1: register fault_i once before evaluation (+1 cycle latency); 0: evaluate fault_i directly
IdxWidth, cf_math_pkg::idx_width(NumSources), width of the source index (derived; do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fault_i  in  NumSources×2  per-source flags; [i][0] corrected, [i][1] uncorrectable
mask_i  in  NumSources  1 = ignore source i (both bits)
clear_i  in  1  single-cycle request: clear counters, state, capture, irq
threshold_i  in  CntWidth  corrected-count irq threshold; 0 disables the corrected irq
corr_cnt_o  out  CntWidth  saturating count of corrected events
uncorr_cnt_o  out  CntWidth  saturating count of uncorrectable events
state_o  out  2  health: 0 OK, 1 CORRECTED, 2 FAILED
first_valid_o  out  1  first-uncorrectable capture valid
first_idx_o  out  IdxWidth  source index of first uncorrectable fault
irq_o  out  1  level interrupt

Behaviour:
- Reset: all outputs 0, state OK, input register 0.
- Evaluated vector: f = (RegInputs ? fault_q : fault_i) with masked sources forced to 00. mask_i applies at evaluation time (not at the input register).
- Per cycle: nc = popcount(f[*][0]), nu = popcount(f[*][1]). A source with both bits set counts in both.
- Counters: cnt_next = min(cnt + n, 2^CntWidth−1). Compute the sum at CntWidth+clog2(NumSources+1) bits, then saturate. Counters never wrap; a saturated counter holds until clear.
- Latency: with RegInputs=0, a fault present in cycle k is visible on all outputs in cycle k+1. With RegInputs=1, it is visible in cycle k+2.
- FSM (state_o):
  - OK → CORRECTED when nc>0 and nu=0.
  - OK or CORRECTED → FAILED when nu>0.
  - CORRECTED stays CORRECTED without clear.
  - FAILED is absorbing; only clear_i or reset exits it.
- First capture: on the first cycle with nu>0 while first_valid_o=0, set first_valid_o=1 and first_idx_o = lowest index i with f[i][1]=1. Later faults do not overwrite the capture.
- irq_o (registered) = (state_next==FAILED) | (threshold_i≠0 & corr_cnt_next ≥ threshold_i). A mid-run change of threshold_i takes effect on the next cycle's evaluation.
- clear_i:
  - Next cycle, counters = saturate(nc / nu of the same cycle), i.e. a fault in the clear cycle is counted after the clear, not lost.
  - State is recomputed from OK using the same-cycle f.
  - Capture is reset, then re-captured if nu>0 in that cycle.
  - The input register (RegInputs=1) is not cleared, so a fault already in flight is still counted in the following cycle.
- Reset mid-operation: asynchronous clear of all state, including the input register. No outputs glitch high during reset.
- NumSources=1: IdxWidth=1, first_idx_o always 0.
- Assertions (sim only):
  - clear_i is never X after reset.
  - threshold_i is never X after reset.

Test Plan:
- Reset, RegInputs=1, fault_i=0 for 10 cycles -> all outputs 0, state_o=0.
- Corrected burst: sources 2 and 5 bit0=1 for 3 cycles, threshold_i=6 -> corr_cnt_o steps 2,4,6 starting 2 cycles after the first fault; state_o=1; irq_o rises in the same cycle corr_cnt_o shows 6.
- Uncorrectable:
  - Cycle k: sources 9 and 3 bit1=1. Expect uncorr_cnt_o=2, first_idx_o=3, first_valid_o=1, state_o=2, irq_o=1.
  - Later: source 1 bit1=1. Expect first_idx_o stays 3 and uncorr_cnt_o=3.
- Saturation: CntWidth=4, all 16 sources bit0=1 for 2 cycles -> corr_cnt_o=15 (not wrapped); stays 15 until clear.
- Clear + same-cycle fault: clear_i=1 while source 0 bit1=1 (RegInputs=0) -> next cycle uncorr_cnt_o=1, corr_cnt_o=0, state_o=2, first_idx_o=0. With mask_i[0]=1 instead, expect all outputs 0 and irq_o=0.
- Async reset asserted mid-burst (not clock-aligned) -> outputs 0 immediately. After release, the first fault is counted from 0.
